ps2_key_tracker: RTL

Parametrised key-event tracker between the PS/2 byte receiver and the display/ASCII consumers. It decodes the raw scan-code stream (set 2) into make/break events, including the `E0` extended prefix and the `F0` break prefix. It tracks up to `SLOTS` simultaneously held keys, so typematic repeats are suppressed and multi-key chords are reported correctly. Events are buffered in a FIFO with a valid/ready handshake, and the block keeps press and held-key counters for the seven-segment debug display.

---
 rtl/ps2_pkg.sv | 45 ++++
 rtl/ps2_event_fifo.sv | 63 ++++++
 rtl/ps2_key_tracker.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 key tracker: scan-code set 2 control
//   bytes, the prefix FSM state type, the event record carried through the
//   event FIFO, and small byte-classification helpers.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  // The pause key sends E1 followed by seven more bytes that carry no
  // make/break meaning for the tracker.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] code;
  } ps2_event_t;

  localparam int EVENT_W = $bits(ps2_event_t);

  // Keyboard status / host-protocol bytes that never start a key sequence.
  function automatic logic is_noise(input logic [7:0] b);
    return (b == 8'h00) || (b == PS2_BAT) || (b == PS2_ECHO) ||
           (b == PS2_ACK) || (b == PS2_RESEND) || (b == 8'hFF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
//   Synchronous FIFO of event records. A push and a pop in the same cycle
//   are both honoured, including when the FIFO is full. The head word reads
//   as zero while the FIFO is empty so downstream fields are clean.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (pointers only)
//   i_push       write i_data this cycle (ignored when full and not popping)
//   i_data       record to write
//   i_pop        consume the head this cycle (ignored when empty)
//   o_data       head record (zero when empty)
//   o_empty      no records stored
//   o_full       DEPTH records stored
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Decodes a PS/2 set-2 scan byte stream into make/break key events,
//   tracks up to SLOTS held keys to recognise typematic repeats, and
//   queues events for the consumer through a valid/ready FIFO.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_byte   one-cycle strobe with a received scan byte
//   ev_valid, ev_ready  event FIFO head handshake
//   ev_code, ev_ext     head key code (prefixes stripped) and E0 flag
//   ev_break, ev_repeat head is a release / a forwarded typematic repeat
//   press_count         new presses, wraps
//   held_count          occupied slots
//   table_full          every slot occupied
//   overflow            sticky: an event was lost to a full FIFO
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int SLOTS      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int REPEAT_EN  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_byte,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [7:0]                 ev_code,
  output logic                       ev_ext,
  output logic                       ev_break,
  output logic                       ev_repeat,
  output logic [CNT_W-1:0]           press_count,
  output logic [$clog2(SLOTS+1)-1:0] held_count,
  output logic                       table_full,
  output logic                       overflow
);

  localparam int   HC_W    = $clog2(SLOTS+1);
  localparam int   IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic FWD_REP = (REPEAT_EN != 0);

  // Prefix FSM and pause skip counter
  ps2_state_t r_state;
  ps2_state_t w_state_nxt;
  logic [2:0] r_skip;
  logic [2:0] w_skip_nxt;

  // Decoded key event for the current strobe
  logic       w_ev_make;
  logic       w_ev_brk;
  logic       w_ev_ext;
  logic [8:0] w_id;

  // Slot table
  logic [SLOTS-1:0] r_slot_vld;
  logic [8:0]       r_slot_id [SLOTS];
  logic [SLOTS-1:0] w_slot_vld_nxt;
  logic             w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_do_alloc;
  logic             w_do_clear;
  logic [HC_W-1:0]  w_held_nxt;

  // Counters / status
  logic [CNT_W-1:0] r_press_cnt;
  logic [HC_W-1:0]  r_held_cnt;
  logic             r_table_full;
  logic             r_overflow;
  logic             w_new_press;

  // FIFO side
  logic             w_push;
  logic             w_pop;
  ps2_event_t       w_push_ev;
  logic [EVENT_W-1:0] w_fifo_dout;
  ps2_event_t       w_head;
  logic             w_fifo_empty;
  logic             w_fifo_full;

  // ---------------------------------------------------------------------
  // Prefix FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Prefix FSM: next state
  // While the skip counter runs the FSM is parked in IDLE and every byte
  // is swallowed, whatever its value.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    if (in_valid) begin
      if (r_skip != 3'd0) begin
        w_skip_nxt = r_skip - 3'd1;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (in_byte == PS2_EXT)        w_state_nxt = ST_EXT;
            else if (in_byte == PS2_BRK)   w_state_nxt = ST_BRK;
            else if (in_byte == PS2_PAUSE) w_skip_nxt  = PAUSE_TAIL;
          end
          ST_EXT: begin
            if (in_byte == PS2_BRK)      w_state_nxt = ST_EXT_BRK;
            else if (in_byte == PS2_EXT) w_state_nxt = ST_EXT;
            else                         w_state_nxt = ST_IDLE;
          end
          ST_BRK, ST_EXT_BRK: w_state_nxt = ST_IDLE;
          default:            w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Prefix FSM: outputs (decoded make/break for this strobe)
  // A stray prefix after F0 is dropped rather than reported as a break.
  // ---------------------------------------------------------------------
  always_comb begin
    w_ev_make = 1'b0;
    w_ev_brk  = 1'b0;
    w_ev_ext  = 1'b0;
    if (in_valid && (r_skip == 3'd0)) begin
      unique case (r_state)
        ST_IDLE: begin
          w_ev_make = !is_prefix(in_byte) && !is_noise(in_byte) &&
                      (in_byte != PS2_PAUSE);
        end
        ST_EXT: begin
          w_ev_make = !is_prefix(in_byte);
          w_ev_ext  = 1'b1;
        end
        ST_BRK: begin
          w_ev_brk = !is_prefix(in_byte);
        end
        ST_EXT_BRK: begin
          w_ev_brk = !is_prefix(in_byte);
          w_ev_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_id = {w_ev_ext, in_byte};

  // ---------------------------------------------------------------------
  // Slot lookup: hit search and lowest free slot
  // ---------------------------------------------------------------------
  always_comb begin
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!w_hit && r_slot_vld[i] && (r_slot_id[i] == w_id)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
    // Scan downward so the last assignment is the lowest free index.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_slot_vld[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign w_do_alloc  = w_ev_make && !w_hit && w_free_found;
  assign w_do_clear  = w_ev_brk && w_hit;
  assign w_new_press = w_ev_make && !w_hit;

  // Next table state is computed here so the registered held count and
  // full flag land on the same edge as the table itself.
  always_comb begin
    w_slot_vld_nxt = r_slot_vld;
    if (w_do_alloc) w_slot_vld_nxt[w_free_idx] = 1'b1;
    if (w_do_clear) w_slot_vld_nxt[w_hit_idx]  = 1'b0;
    w_held_nxt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_held_nxt = w_held_nxt + HC_W'(w_slot_vld_nxt[i]);
    end
  end

  // ---------------------------------------------------------------------
  // Table, counters and status registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot_vld   <= '0;
      r_press_cnt  <= '0;
      r_held_cnt   <= '0;
      r_table_full <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_slot_vld   <= w_slot_vld_nxt;
      r_held_cnt   <= w_held_nxt;
      r_table_full <= &w_slot_vld_nxt;
      if (w_new_press) r_press_cnt <= r_press_cnt + 1'b1;
      if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_alloc) r_slot_id[w_free_idx] <= w_id;
  end

  // ---------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------
  assign w_push = w_ev_brk || (w_ev_make && (!w_hit || FWD_REP));
  assign w_pop  = ev_ready && !w_fifo_empty;

  always_comb begin
    w_push_ev      = '0;
    w_push_ev.ext  = w_ev_ext;
    w_push_ev.brk  = w_ev_brk;
    w_push_ev.rep  = w_ev_make && w_hit;
    w_push_ev.code = in_byte;
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_ev),
    .i_pop   (ev_ready),
    .o_data  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign w_head = w_fifo_dout;

  assign ev_valid    = !w_fifo_empty;
  assign ev_code     = w_head.code;
  assign ev_ext      = w_head.ext;
  assign ev_break    = w_head.brk;
  assign ev_repeat   = w_head.rep;
  assign press_count = r_press_cnt;
  assign held_count  = r_held_cnt;
  assign table_full  = r_table_full;
  assign overflow    = r_overflow;

endmodule
